// File: rtl/serial_to_parallel_buffer_if.sv
// Bus bundle for serial_to_parallel_buffer: serial bit stream in,
// assembled words out through a one-entry valid/ready holding register.
interface serial_to_parallel_buffer_if #(
    parameter int WIDTH = 8
);
    logic                     bit_in;
    logic                     bit_valid;
    logic                     clear;
    logic [WIDTH-1:0]         word_out;
    logic                     word_valid;
    logic                     word_ready;
    logic [$clog2(WIDTH)-1:0] bit_count;
    logic                     overflow;

    // Driver of the bit stream and consumer of the words.
    modport master (
        output bit_in, bit_valid, clear, word_ready,
        input  word_out, word_valid, bit_count, overflow
    );

    // The assembler itself.
    modport slave (
        input  bit_in, bit_valid, clear, word_ready,
        output word_out, word_valid, bit_count, overflow
    );
endinterface

// File: rtl/serial_to_parallel_buffer.sv
// Assembles a 1-bit-per-clock stream into WIDTH-bit words and presents each
// word through a one-entry holding register. A word that completes while the
// held word is still waiting (and not being taken) is dropped and flagged in
// the sticky overflow bit.
//
// Handshake: a word transfers on a rising edge where word_valid=1 and
// word_ready=1. word_valid is a pure register output (never a combinational
// function of word_ready), word_ready while empty is ignored, and word_out is
// stable while word_valid=1 and word_ready=0.
module serial_to_parallel_buffer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    serial_to_parallel_buffer_if.slave bus,
    output logic                       dbg_state_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic             ovf_q,   ovf_d;

    logic [WIDTH-1:0] shifted;
    logic             take_bit;
    logic             complete;
    logic             handshake;

    // Shift direction decides whether the first bit ends up at the MSB or LSB.
    assign shifted   = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.bit_in}
                                 : {bus.bit_in, shift_q[WIDTH-1:1]};
    // clear beats an incoming bit, including the one that would complete a word.
    assign take_bit  = bus.bit_valid && !bus.clear;
    assign complete  = take_bit && (count_q == LAST_CNT);
    assign handshake = (state_q == FULL) && bus.word_ready;

    // Next-state logic for the assembler, holding register FSM and overflow flag.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        state_d = state_q;
        word_d  = word_q;
        ovf_d   = ovf_q;

        if (bus.clear) begin
            shift_d = '0;
            count_d = '0;
        end else if (take_bit) begin
            shift_d = shifted;
            count_d = complete ? '0 : count_q + CW'(1);
        end

        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = FULL;
                    word_d  = shifted;
                end
            end
            default: begin
                if (complete && handshake) begin
                    word_d = shifted;
                end else if (complete) begin
                    // Held word not taken: keep it, drop the new one.
                    ovf_d = 1'b1;
                end else if (handshake) begin
                    state_d = EMPTY;
                end
            end
        endcase

        // complete already excludes clear, so clear always leaves overflow low.
        if (bus.clear) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            count_q <= '0;
            state_q <= EMPTY;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            state_q <= state_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.bit_count  = count_q;
    assign bus.overflow   = ovf_q;
    assign dbg_state_o    = state_q[0];
endmodule

// File: tb/tb_serial_to_parallel_buffer.sv
// Directed bench for serial_to_parallel_buffer: one MSB-first and one
// LSB-first instance share the same stimulus; each test resets first.
module tb_serial_to_parallel_buffer;
    logic clk;
    logic rst_n;
    logic bit_in;
    logic bit_valid;
    logic clear;
    logic word_ready;
    logic dbg_a;
    logic dbg_b;

    int errors;
    int checks;

    serial_to_parallel_buffer_if #(.WIDTH(8)) a_if ();
    serial_to_parallel_buffer_if #(.WIDTH(8)) b_if ();

    assign a_if.bit_in     = bit_in;
    assign a_if.bit_valid  = bit_valid;
    assign a_if.clear      = clear;
    assign a_if.word_ready = word_ready;
    assign b_if.bit_in     = bit_in;
    assign b_if.bit_valid  = bit_valid;
    assign b_if.clear      = clear;
    assign b_if.word_ready = word_ready;

    serial_to_parallel_buffer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (a_if.slave),
        .dbg_state_o (dbg_a)
    );

    serial_to_parallel_buffer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (b_if.slave),
        .dbg_state_o (dbg_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Drivers
    task automatic send_bit(input logic b, input logic clr);
        bit_in    = b;
        bit_valid = 1'b1;
        clear     = clr;
        tick();
        bit_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic send_msb(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'h00) begin errors++; $display("FAIL rst_word: got %h want 00", a_if.word_out); end
        checks++; if (a_if.bit_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", a_if.bit_count); end
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", a_if.overflow); end
        checks++; if (dbg_a !== 1'b0) begin errors++; $display("FAIL rst_state: got %b want 0", dbg_a); end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        do_reset();
        word_ready = 1'b1;
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", a_if.word_valid); end
        checks++; if (a_if.bit_count !== 3'd7) begin errors++; $display("FAIL basic_count7: got %0d want 7", a_if.bit_count); end
        send_bit(w[0], 1'b0);
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'hA5) begin errors++; $display("FAIL basic_word: got %h want a5", a_if.word_out); end
        checks++; if (a_if.bit_count !== 3'd0) begin errors++; $display("FAIL basic_wrap: got %0d want 0", a_if.bit_count); end
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", a_if.overflow); end
        tick();
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'hA5) begin errors++; $display("FAIL basic_hold_after: got %h want a5", a_if.word_out); end
    endtask

    task automatic test_backpressure();
        do_reset();
        word_ready = 1'b0;
        send_msb(8'hA5);
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", a_if.word_valid); end
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf0: got %b want 0", a_if.overflow); end
        send_msb(8'h3C);
        checks++; if (a_if.word_out !== 8'hA5) begin errors++; $display("FAIL bp_word_kept: got %h want a5", a_if.word_out); end
        checks++; if (a_if.overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf1: got %b want 1", a_if.overflow); end
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL bp_still_full: got %b want 1", a_if.word_valid); end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", a_if.word_valid); end
        checks++; if (a_if.overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", a_if.overflow); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %b want 0", a_if.overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        do_reset();
        word_ready = 1'b0;
        send_msb(8'h11);
        w = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        checks++; if (a_if.word_out !== 8'h11) begin errors++; $display("FAIL b2b_hold11: got %h want 11", a_if.word_out); end
        word_ready = 1'b1;
        send_bit(w[0], 1'b0);
        word_ready = 1'b0;
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'h22) begin errors++; $display("FAIL b2b_word: got %h want 22", a_if.word_out); end
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", a_if.overflow); end
        tick();
        checks++; if (a_if.word_out !== 8'h22) begin errors++; $display("FAIL b2b_stable: got %h want 22", a_if.word_out); end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", a_if.word_valid); end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        do_reset();
        word_ready = 1'b1;
        w = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_if.bit_count !== 3'(i)) begin errors++; $display("FAIL gap_count%0d: got %0d want %0d", i, a_if.bit_count, i); end
            send_bit(w[7-i], 1'b0);
            if (i == 1 || i == 4) begin
                tick();
                checks++; if (a_if.bit_count !== 3'(i + 1)) begin errors++; $display("FAIL gap_hold%0d: got %0d want %0d", i, a_if.bit_count, i + 1); end
            end
        end
        checks++; if (a_if.word_out !== 8'hC3) begin errors++; $display("FAIL gap_word: got %h want c3", a_if.word_out); end
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b want 1", a_if.word_valid); end
        tick();
    endtask

    task automatic test_clear_reset();
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        checks++; if (a_if.bit_count !== 3'd3) begin errors++; $display("FAIL clr_count3: got %0d want 3", a_if.bit_count); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (a_if.bit_count !== 3'd0) begin errors++; $display("FAIL clr_count0: got %0d want 0", a_if.bit_count); end
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL clr_no_early: got %b want 0", a_if.word_valid); end
        send_bit(1'b1, 1'b0);
        checks++; if (a_if.word_valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b want 1", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'hFF) begin errors++; $display("FAIL clr_word: got %h want ff", a_if.word_out); end
        tick();

        word_ready = 1'b0;
        send_msb(8'h5A);
        send_msb(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        checks++; if (a_if.overflow !== 1'b1 || a_if.word_valid !== 1'b1 || a_if.bit_count !== 3'd5) begin
            errors++; $display("FAIL prerst_state: got ovf=%b valid=%b count=%0d want 1 1 5", a_if.overflow, a_if.word_valid, a_if.bit_count);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (a_if.word_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", a_if.word_valid); end
        checks++; if (a_if.word_out !== 8'h00) begin errors++; $display("FAIL mrst_word: got %h want 00", a_if.word_out); end
        checks++; if (a_if.bit_count !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d want 0", a_if.bit_count); end
        checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL mrst_ovf: got %b want 0", a_if.overflow); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        do_reset();
        word_ready = 1'b1;
        seq = 8'b0011_0101;
        for (int i = 0; i < 8; i++) send_bit(seq[i], 1'b0);
        checks++; if (b_if.word_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b want 1", b_if.word_valid); end
        checks++; if (b_if.word_out !== 8'h35) begin errors++; $display("FAIL lsb_word: got %h want 35", b_if.word_out); end
        tick();
        checks++; if (b_if.word_valid !== 1'b0) begin errors++; $display("FAIL lsb_drained: got %b want 0", b_if.word_valid); end
        for (int i = 0; i < 7; i++) send_bit(seq[i], 1'b0);
        send_bit(seq[7], 1'b1);
        checks++; if (b_if.word_valid !== 1'b0) begin errors++; $display("FAIL lsb_clr_valid: got %b want 0", b_if.word_valid); end
        checks++; if (b_if.bit_count !== 3'd0) begin errors++; $display("FAIL lsb_clr_count: got %0d want 0", b_if.bit_count); end
        tick();
        checks++; if (b_if.word_valid !== 1'b0) begin errors++; $display("FAIL lsb_clr_later: got %b want 0", b_if.word_valid); end
    endtask

    // Sequence and report
    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_gaps();
        test_clear_reset();
        test_lsb_first();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel_buffer.md
Name: serial_to_parallel_buffer

Overview:
- Downstream consumer of the single-bit registered buffer stage. Takes its 1-bit-per-clock output stream and assembles WIDTH-bit words.
- Presents each completed word through a one-entry holding register with a valid/ready handshake.
- Flags a lost word when the consumer back-pressures and a new word completes before the held one is taken.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- bit_in  input  1  serial data bit (driven by the upstream registered buffer).
- bit_valid  input  1  bit_in is sampled this cycle when high.
- clear  input  1  synchronous discard of the partial word and of the overflow flag.
- word_out  output  WIDTH  assembled word; valid only while word_valid=1.
- word_valid  output  1  holding register full.
- word_ready  input  1  consumer accepts word_out this cycle.
- bit_count  output  $clog2(WIDTH)  bits collected in the current partial word.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a rising edge): word_out=0, word_valid=0, bit_count=0, overflow=0, shift register=0.
- Reset mid-word or mid-handshake aborts everything with no partial output.
- Assembly:
  - On bit_valid=1, bit_in is shifted into the shift register in the direction set by MSB_FIRST, and bit_count increments.
  - Gaps (bit_valid=0) hold all assembly state.
- Completion: bit_valid=1 with bit_count=WIDTH-1 completes a word; bit_count wraps to 0 on the same edge.
- Holding register FSM, states EMPTY (word_valid=0) and FULL (word_valid=1):
  - EMPTY + completion -> FULL; word_out is loaded. Latency is 1 cycle: word_valid rises on the edge after the last bit is sampled.
  - FULL + word_valid&word_ready without completion -> EMPTY; word_out holds its last value.
  - FULL + handshake + completion in the same cycle -> stays FULL and word_out is loaded with the new word; no overflow.
  - FULL + completion without handshake -> stays FULL. word_out is unchanged, the new word is discarded, and overflow is set to 1.
  - While FULL and word_ready=0, word_out is stable.
- Handshake rules:
  - A transfer occurs at a rising edge with word_valid=1 and word_ready=1.
  - word_ready while EMPTY is ignored.
  - word_valid does not depend combinationally on word_ready.
- clear (when rst_n=1):
  - Resets the shift register and bit_count to 0, and clears overflow.
  - Does not affect the holding register or word_valid.
  - clear with bit_valid in the same cycle: clear wins and the bit is discarded, including the completing bit.
  - clear with a handshake in the same cycle: the handshake still completes.
- overflow:
  - Once set, it stays 1 until clear or reset.
  - Simultaneous clear and a drop event -> overflow=0.

Test Plan:
- WIDTH=8, MSB_FIRST=1, word_ready=1; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> word_valid=1 for exactly one cycle, the cycle after the 8th bit. word_out=8'hA5, overflow=0.
- Back-pressure, word_ready=0: send 0xA5 then 0x3C -> word_out stays 8'hA5 and overflow=1 after the 0x3C completes. Then raise word_ready for 1 cycle -> word_valid=0 and overflow stays 1.
- Back-to-back: hold 0x11 with word_ready=0, stream 0x22, raise word_ready only on the cycle of the last 0x22 bit -> 0x11 is accepted and word_out=8'h22 valid next cycle. overflow=0.
- Gappy input: send 0xC3 with bit_valid=0 cycles inserted after bits 2 and 5 -> word_out=8'hC3. bit_count reads 0..7, holding during gaps.
- Clear and reset:
  - 3 bits, then clear, then 8 ones -> single word 8'hFF, with bit_count=0 the cycle after clear.
  - Separately, rst_n=0 after 5 bits with FULL -> all outputs 0 next cycle.
- MSB_FIRST=0: bits 1,0,1,0,1,1,0,0 -> word_out=8'h35. A clear on the same cycle as the 8th bit -> no word_valid and bit_count=0.
